// File: rtl/c3lib_ckg_en_ctrl.sv
// Clock-enable controller: turns an activity request into a registered clk_en with idle hysteresis
// and a programmable wake delay before clk_rdy. All outputs are flops; no input-to-output comb path.
module c3lib_ckg_en_ctrl #(
    parameter int IDLE_W = 8,
    parameter int WAKE_W = 4,
    parameter int RST_ON = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              force_on,
    input  logic [IDLE_W-1:0] cfg_idle_limit,
    input  logic [WAKE_W-1:0] cfg_wake_dly,
    output logic              clk_en,
    output logic              clk_rdy,
    output logic [1:0]        gate_state
);

    localparam int CNT_W = (IDLE_W > WAKE_W) ? IDLE_W : WAKE_W;

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_WAKE = 2'b01;
    localparam logic [1:0] ST_ON   = 2'b10;
    localparam logic [1:0] ST_IDLE = 2'b11;

    localparam logic [1:0] ST_RST = (RST_ON != 0) ? ST_ON : ST_OFF;

    logic             act;
    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_zero;

    assign act      = req | force_on;
    assign cnt_zero = (cnt == '0);

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            ST_OFF: begin
                if (act) begin
                    next_state = ST_WAKE;
                    cnt_nxt    = CNT_W'(cfg_wake_dly);
                end
            end
            // Wake is never aborted: the consumer always sees a settled clock once started.
            ST_WAKE: begin
                if (cnt_zero) begin
                    next_state = ST_ON;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_ON: begin
                if (!act) begin
                    next_state = ST_IDLE;
                    cnt_nxt    = CNT_W'(cfg_idle_limit);
                end
            end
            default: begin
                // Renewed activity beats expiry so the clock never drops on a late request.
                if (act) begin
                    next_state = ST_ON;
                    cnt_nxt    = '0;
                end else if (cnt_zero) begin
                    next_state = ST_OFF;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RST;
            cnt     <= '0;
            clk_en  <= (ST_RST != ST_OFF);
            clk_rdy <= (ST_RST == ST_ON) || (ST_RST == ST_IDLE);
        end else begin
            state   <= next_state;
            cnt     <= cnt_nxt;
            clk_en  <= (next_state != ST_OFF);
            clk_rdy <= (next_state == ST_ON) || (next_state == ST_IDLE);
        end
    end

    assign gate_state = state;

    act_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(act));

    rdy_after_en: assert property (@(posedge clk) disable iff (rst)
        $rose(clk_rdy) |-> $past(clk_en));

endmodule

// File: tb/tb_c3lib_ckg_en_ctrl.sv
// Directed bench for c3lib_ckg_en_ctrl: one instance resets ON, the other resets OFF.
module tb_c3lib_ckg_en_ctrl;

    logic       clk;
    logic       rst_on_dut;
    logic       rst_off_dut;
    logic       req;
    logic       force_on;
    logic [7:0] cfg_idle_limit;
    logic [3:0] cfg_wake_dly;

    logic       en1, rdy1;
    logic [1:0] st1;
    logic       en0, rdy0;
    logic [1:0] st0;

    int errors = 0;
    int checks = 0;

    c3lib_ckg_en_ctrl #(.IDLE_W(8), .WAKE_W(4), .RST_ON(1)) dut_on (
        .clk            (clk),
        .rst            (rst_on_dut),
        .req            (req),
        .force_on       (force_on),
        .cfg_idle_limit (cfg_idle_limit),
        .cfg_wake_dly   (cfg_wake_dly),
        .clk_en         (en1),
        .clk_rdy        (rdy1),
        .gate_state     (st1)
    );

    c3lib_ckg_en_ctrl #(.IDLE_W(8), .WAKE_W(4), .RST_ON(0)) dut_off (
        .clk            (clk),
        .rst            (rst_off_dut),
        .req            (req),
        .force_on       (force_on),
        .cfg_idle_limit (cfg_idle_limit),
        .cfg_wake_dly   (cfg_wake_dly),
        .clk_en         (en0),
        .clk_rdy        (rdy0),
        .gate_state     (st0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_on_dut  = 1'b1;
        rst_off_dut = 1'b1;
        req = 1'b0; force_on = 1'b0;
        cfg_idle_limit = 8'd4; cfg_wake_dly = 4'd0;
        repeat (3) step();
        checks++;
        if ({st1, en1, rdy1} !== 4'b1011) begin
            errors++;
            $display("FAIL reset_on_state got %b want 1011", {st1, en1, rdy1});
        end
        checks++;
        if ({st0, en0, rdy0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_off_state got %b want 0000", {st0, en0, rdy0});
        end
        rst_on_dut  = 1'b0;
        rst_off_dut = 1'b0;
        step();
        checks++;
        if ({st1, en1, rdy1} !== 4'b1111) begin
            errors++;
            $display("FAIL release_idle got %b want 1111", {st1, en1, rdy1});
        end
        repeat (4) step();
        checks++;
        if ({st1, en1, rdy1} !== 4'b1111) begin
            errors++;
            $display("FAIL idle_edge5 got %b want 1111", {st1, en1, rdy1});
        end
        step();
        checks++;
        if ({st1, en1, rdy1} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_expire_edge6 got %b want 0000", {st1, en1, rdy1});
        end
    endtask

    task automatic test_wake_pulse();
        cfg_wake_dly = 4'd3; cfg_idle_limit = 8'd4;
        req = 1'b1;
        step();
        req = 1'b0;
        checks++;
        if ({st1, en1, rdy1} !== 4'b0110) begin
            errors++;
            $display("FAIL wake_edge1 got %b want 0110", {st1, en1, rdy1});
        end
        repeat (3) step();
        checks++;
        if ({st1, en1, rdy1} !== 4'b0110) begin
            errors++;
            $display("FAIL wake_edge4 got %b want 0110", {st1, en1, rdy1});
        end
        step();
        checks++;
        if ({st1, en1, rdy1} !== 4'b1011) begin
            errors++;
            $display("FAIL wake_on_edge5 got %b want 1011", {st1, en1, rdy1});
        end
        step();
        checks++;
        if (st1 !== 2'b11) begin
            errors++;
            $display("FAIL wake_idle_edge6 got %b want 11", st1);
        end
        repeat (4) step();
        checks++;
        if ({st1, en1} !== 3'b111) begin
            errors++;
            $display("FAIL wake_idle_edge10 got %b want 111", {st1, en1});
        end
        step();
        checks++;
        if ({st1, en1, rdy1} !== 4'b0000) begin
            errors++;
            $display("FAIL wake_off_edge11 got %b want 0000", {st1, en1, rdy1});
        end
    endtask

    task automatic test_idle_race();
        logic dropped;
        cfg_idle_limit = 8'd2; cfg_wake_dly = 4'd0;
        dropped = 1'b0;
        req = 1'b1;
        step();
        step();
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!en1) dropped = 1'b1;
        end
        checks++;
        if (st1 !== 2'b11) begin
            errors++;
            $display("FAIL race_in_idle got %b want 11", st1);
        end
        req = 1'b1;
        step();
        if (!en1) dropped = 1'b1;
        checks++;
        if ({st1, rdy1} !== 3'b101) begin
            errors++;
            $display("FAIL race_back_on got %b want 101", {st1, rdy1});
        end
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL race_en_dropped got %b want 0", dropped);
        end
        req = 1'b0;
        repeat (4) step();
        checks++;
        if ({st1, en1} !== 3'b000) begin
            errors++;
            $display("FAIL race_off got %b want 000", {st1, en1});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] want [5];
        logic [3:0] req_seq;
        logic       dropped;
        want[0] = 2'b00; want[1] = 2'b01; want[2] = 2'b10; want[3] = 2'b11; want[4] = 2'b10;
        req_seq = 4'b1011;
        cfg_idle_limit = 8'd0; cfg_wake_dly = 4'd0;
        dropped = 1'b0;
        checks++;
        if (st1 !== want[0]) begin
            errors++;
            $display("FAIL b2b_state0 got %b want %b", st1, want[0]);
        end
        for (int i = 1; i < 5; i++) begin
            req = req_seq[i-1];
            step();
            if (!en1) dropped = 1'b1;
            checks++;
            if (st1 !== want[i]) begin
                errors++;
                $display("FAIL b2b_state%0d got %b want %b", i, st1, want[i]);
            end
        end
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL b2b_en_dropped got %b want 0", dropped);
        end
        req = 1'b0;
        step();
        step();
        checks++;
        if ({st1, en1} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_off got %b want 000", {st1, en1});
        end
    endtask

    task automatic test_force_on();
        int bad;
        cfg_idle_limit = 8'd3; cfg_wake_dly = 4'd0;
        req = 1'b0; force_on = 1'b1;
        step();
        step();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if ({st1, en1, rdy1} !== 4'b1011) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL force_hold bad_cycles got %0d want 0", bad);
        end
        force_on = 1'b0;
        repeat (4) step();
        checks++;
        if ({st1, en1} !== 3'b111) begin
            errors++;
            $display("FAIL force_idle_edge4 got %b want 111", {st1, en1});
        end
        step();
        checks++;
        if ({st1, en1, rdy1} !== 4'b0000) begin
            errors++;
            $display("FAIL force_off_edge5 got %b want 0000", {st1, en1, rdy1});
        end
    endtask

    task automatic test_reset_mid_wake();
        cfg_wake_dly = 4'd4; cfg_idle_limit = 8'd1;
        req = 1'b1;
        repeat (3) step();
        checks++;
        if ({st0, en0, rdy0} !== 4'b0110) begin
            errors++;
            $display("FAIL rst_wake_pre got %b want 0110", {st0, en0, rdy0});
        end
        rst_off_dut = 1'b1;
        step();
        checks++;
        if ({st0, en0, rdy0} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_wake_off got %b want 0000", {st0, en0, rdy0});
        end
        rst_off_dut = 1'b0;
        repeat (5) step();
        checks++;
        if ({st0, en0, rdy0} !== 4'b0110) begin
            errors++;
            $display("FAIL rst_wake_restart_edge5 got %b want 0110", {st0, en0, rdy0});
        end
        step();
        checks++;
        if ({st0, en0, rdy0} !== 4'b1011) begin
            errors++;
            $display("FAIL rst_wake_on_edge6 got %b want 1011", {st0, en0, rdy0});
        end
        req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wake_pulse();
        test_idle_race();
        test_back_to_back();
        test_force_on();
        test_reset_mid_wake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
